cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_cpu_core.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: single-cycle core for a subset of the Thumb-16 instruction set.
// A 256 x 16 program memory is downloaded while write=1. Once write drops,
// one instruction executes per clock. Address 0x20 is a memory-mapped GPIO register.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset (PC, regs, flags, GPIO)
//   write                    program download enable; holds PC at 0, no execution
//   write_instruction_index  halfword index written during download
//   write_instruction        byte-swapped instruction halfword
//   gpio_state               GPIO register contents
//   index                    PC (halfword index) of the instruction executing now
module cpu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [7:0]  write_instruction_index,
  input  logic [15:0] write_instruction,
  output logic [31:0] gpio_state,
  output logic [31:0] index
);

  localparam logic [31:0] GpioAddr = 32'h0000_0020;

  logic [15:0] prog_mem [256];

  logic [7:0]  pc_q, pc_d;
  logic [31:0] regs_q [8];
  logic        n_q, z_q, c_q, v_q;
  logic        n_d, z_d, c_d, v_d;
  logic [31:0] gpio_q, gpio_d;

  logic [15:0] instr;
  logic [31:0] r_lo, r_mid, r_hi, r_op3;
  logic [31:0] mem_addr;

  logic        reg_we;
  logic [2:0]  reg_wa;
  logic [31:0] res;
  logic [33:0] sum;
  logic [32:0] sh;
  logic        use_sum, use_sh, set_nz;
  logic [31:0] op_b;
  logic [7:0]  sh_amt;

  // Returns {V, C, result} of a + b + cin.
  function automatic logic [33:0] add_c(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return {(a[31] == b[31]) && (s[31] != a[31]), s[32], s[31:0]};
  endfunction

  // Returns {C, result}. kind: 0 LSL, 1 LSR, 2 ASR, 3 ROR. Amount 0 keeps C.
  function automatic logic [32:0] shift_c(input logic [1:0] kind, input logic [31:0] val,
                                          input logic [7:0] amt, input logic cin);
    logic [32:0] t;
    logic [31:0] r;
    logic [4:0]  k;
    t = {cin, val};
    r = '0;
    k = amt[4:0];
    if (amt != 8'd0) begin
      unique case (kind)
        2'd0: t = {1'b0, val} << amt;
        2'd1: begin
          // Extra low bit catches the last bit shifted out as carry.
          t = {val, 1'b0} >> amt;
          t = {t[0], t[32:1]};
        end
        2'd2: begin
          if (amt >= 8'd32) begin
            t = {33{val[31]}};
          end else begin
            t = $signed({val, 1'b0}) >>> amt;
            t = {t[0], t[32:1]};
          end
        end
        default: begin
          r = (val >> k) | (val << (6'd32 - {1'b0, k}));
          t = {r[31], r};
        end
      endcase
    end
    return t;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic n, input logic z,
                                     input logic c, input logic v);
    logic p;
    unique case (cond[3:1])
      3'd0:    p = z;
      3'd1:    p = c;
      3'd2:    p = n;
      3'd3:    p = v;
      3'd4:    p = c & ~z;
      3'd5:    p = (n == v);
      3'd6:    p = ~z & (n == v);
      default: p = 1'b0;
    endcase
    // 1110/1111 never branch.
    return (cond[3:1] == 3'd7) ? 1'b0 : (p ^ cond[0]);
  endfunction

  // Program memory has no reset; it survives rst.
  always_ff @(posedge clk) begin
    if (write) begin
      prog_mem[write_instruction_index] <= {write_instruction[7:0], write_instruction[15:8]};
    end
  end

  assign instr    = prog_mem[pc_q];
  assign r_lo     = regs_q[instr[2:0]];
  assign r_mid    = regs_q[instr[5:3]];
  assign r_hi     = regs_q[instr[10:8]];
  assign r_op3    = regs_q[instr[8:6]];
  assign mem_addr = r_mid + {25'd0, instr[10:6], 2'd0};

  always_comb begin
    pc_d    = pc_q + 8'd1;
    gpio_d  = gpio_q;
    reg_we  = 1'b0;
    reg_wa  = instr[2:0];
    res     = '0;
    sum     = '0;
    sh      = '0;
    use_sum = 1'b0;
    use_sh  = 1'b0;
    set_nz  = 1'b0;
    op_b    = '0;
    sh_amt  = '0;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;

    unique case (instr[15:13])
      3'b000: begin
        reg_we = 1'b1;
        if (instr[12:11] == 2'b11) begin
          // ADDS/SUBS register or imm3
          op_b    = instr[10] ? {29'd0, instr[8:6]} : r_op3;
          sum     = instr[9] ? add_c(r_mid, ~op_b, 1'b1) : add_c(r_mid, op_b, 1'b0);
          use_sum = 1'b1;
        end else begin
          // LSR/ASR #0 encode a shift by 32
          sh_amt = ((instr[10:6] == 5'd0) && (instr[12:11] != 2'b00)) ? 8'd32
                                                                       : {3'd0, instr[10:6]};
          sh     = shift_c(instr[12:11], r_mid, sh_amt, c_q);
          use_sh = 1'b1;
        end
      end
      3'b001: begin
        reg_wa = instr[10:8];
        op_b   = {24'd0, instr[7:0]};
        unique case (instr[12:11])
          2'b00: begin res = op_b; reg_we = 1'b1; set_nz = 1'b1; end
          2'b01: begin sum = add_c(r_hi, ~op_b, 1'b1); use_sum = 1'b1; end
          2'b10: begin sum = add_c(r_hi, op_b, 1'b0); use_sum = 1'b1; reg_we = 1'b1; end
          default: begin sum = add_c(r_hi, ~op_b, 1'b1); use_sum = 1'b1; reg_we = 1'b1; end
        endcase
      end
      3'b010: begin
        if (instr[12:10] == 3'b000) begin
          reg_we = 1'b1;
          set_nz = 1'b1;
          unique case (instr[9:6])
            4'h0: res = r_lo & r_mid;
            4'h1: res = r_lo ^ r_mid;
            4'h2: begin sh = shift_c(2'd0, r_lo, r_mid[7:0], c_q); use_sh = 1'b1; end
            4'h3: begin sh = shift_c(2'd1, r_lo, r_mid[7:0], c_q); use_sh = 1'b1; end
            4'h4: begin sh = shift_c(2'd2, r_lo, r_mid[7:0], c_q); use_sh = 1'b1; end
            4'h5: begin sum = add_c(r_lo, r_mid, c_q); use_sum = 1'b1; end
            4'h6: begin sum = add_c(r_lo, ~r_mid, c_q); use_sum = 1'b1; end
            4'h7: begin sh = shift_c(2'd3, r_lo, r_mid[7:0], c_q); use_sh = 1'b1; end
            4'h8: begin res = r_lo & r_mid; reg_we = 1'b0; end
            4'h9: begin sum = add_c(32'd0, ~r_mid, 1'b1); use_sum = 1'b1; end
            4'hA: begin sum = add_c(r_lo, ~r_mid, 1'b1); use_sum = 1'b1; reg_we = 1'b0; end
            4'hB: begin sum = add_c(r_lo, r_mid, 1'b0); use_sum = 1'b1; reg_we = 1'b0; end
            4'hC: res = r_lo | r_mid;
            4'hD: res = r_lo * r_mid;
            4'hE: res = r_lo & ~r_mid;
            default: res = ~r_mid;
          endcase
        end
      end
      3'b011: begin
        if (!instr[12]) begin
          if (instr[11]) begin
            reg_we = 1'b1;
            res    = (mem_addr == GpioAddr) ? gpio_q : 32'd0;
          end else if (mem_addr == GpioAddr) begin
            gpio_d = r_lo;
          end
        end
      end
      3'b110: begin
        if (instr[12] && cond_pass(instr[11:8], n_q, z_q, c_q, v_q)) begin
          pc_d = pc_q + 8'd2 + instr[7:0];
        end
      end
      3'b111: begin
        // Only the low 8 offset bits matter once the target wraps to 8 bits.
        if (instr[12:11] == 2'b00) begin
          pc_d = pc_q + 8'd2 + instr[7:0];
        end
      end
      default: ;
    endcase

    if (use_sum) begin
      res    = sum[31:0];
      c_d    = sum[32];
      v_d    = sum[33];
      set_nz = 1'b1;
    end
    if (use_sh) begin
      res    = sh[31:0];
      c_d    = sh[32];
      set_nz = 1'b1;
    end
    if (set_nz) begin
      n_d = res[31];
      z_d = (res == 32'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= 8'd0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      gpio_q <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (write) begin
      pc_q <= 8'd0;
    end else begin
      pc_q   <= pc_d;
      n_q    <= n_d;
      z_q    <= z_d;
      c_q    <= c_d;
      v_q    <= v_d;
      gpio_q <= gpio_d;
      if (reg_we) begin
        regs_q[reg_wa] <= res;
      end
    end
  end

  assign gpio_state = gpio_q;
  assign index      = {24'd0, pc_q};

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  write_instruction_index = 8'd0;
  logic [15:0] write_instruction = 16'd0;
  logic [31:0] gpio_state;
  logic [31:0] index;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_core dut (
    .clk                     (clk),
    .rst                     (rst),
    .write                   (write),
    .write_instruction_index (write_instruction_index),
    .write_instruction       (write_instruction),
    .gpio_state              (gpio_state),
    .index                   (index)
  );

  always #5 clk = ~clk;

  task automatic load(input int idx, input logic [15:0] word);
    @(negedge clk);
    write = 1'b1;
    write_instruction_index = idx[7:0];
    write_instruction = word;
    @(posedge clk);
  endtask

  // Reset while write is high so the core stays parked until start.
  task automatic hold_reset;
    @(negedge clk);
    write = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic zero_low;
    for (int i = 0; i < 10; i++) load(i, 16'h0000);
  endtask

  task automatic start;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    write = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (index !== 32'd0) begin
      n_fail++; $display("FAIL reset_index: got %h want %h", index, 32'd0);
    end
    n_cmp++;
    if (gpio_state !== 32'd0) begin
      n_fail++; $display("FAIL reset_gpio: got %h want %h", gpio_state, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // SUBS r0,#1 from 0: C=0, N=1, Z=0, V=0 checked through branch outcomes.
  task automatic test_sub_flags;
    logic [15:0] p [10];
    logic [31:0] exp_idx [10];
    p = '{16'h2021, 16'h0020, 16'h0138, 16'h0AD2, 16'h00D4,
          16'hFEE7, 16'h0AD0, 16'h0AD6, 16'h0860, 16'hFEE7};
    exp_idx = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9, 32'd9, 32'd9};
    hold_reset;
    for (int i = 0; i < 10; i++) load(i, p[i]);
    start;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (index !== exp_idx[k]) begin
        n_fail++; $display("FAIL subflags_index[%0d]: got %0d want %0d", k, index, exp_idx[k]);
      end
    end
    n_cmp++;
    if (gpio_state !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL subflags_r0: got %h want %h", gpio_state, 32'hFFFF_FFFF);
    end
  endtask

  // EOR, MVN, LDR, LSR imm, MUL, ASR #0, STR/LDR to unmapped address.
  task automatic test_alu;
    logic [15:0] p [18];
    logic [31:0] want_idx, want_g;
    logic        chk;
    p = '{16'h2021, 16'hF022, 16'h3C23, 16'h5A40, 16'h0A60, 16'hDC43,
          16'h0C60, 16'h0D68, 16'h2D09, 16'h0D60, 16'h5D43, 16'h0D60,
          16'h2E10, 16'h0E60, 16'h4B60, 16'h4F68, 16'h0F60, 16'hFEE7};
    hold_reset;
    for (int i = 0; i < 18; i++) load(i, p[i]);
    start;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      want_idx = (k > 17) ? 32'd17 : 32'(k);
      n_cmp++;
      if (index !== want_idx) begin
        n_fail++; $display("FAIL alu_index[%0d]: got %0d want %0d", k, index, want_idx);
      end
      chk = 1'b1;
      want_g = 32'd0;
      case (k)
        5:  want_g = 32'h0000_00CC;
        7:  want_g = 32'hFFFF_FFC3;
        10: want_g = 32'h0FFF_FFFC;
        12: want_g = 32'hBFFF_FF10;
        15: want_g = 32'hFFFF_FFFF;
        17: want_g = 32'h0000_0000;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        n_cmp++;
        if (gpio_state !== want_g) begin
          n_fail++; $display("FAIL alu_gpio[%0d]: got %h want %h", k, gpio_state, want_g);
        end
      end
    end
  endtask

  task automatic test_gpio_d9;
    logic [15:0] p [6];
    p = '{16'h0020, 16'h0020, 16'hD920, 16'h2021, 16'h0860, 16'hFEE7};
    hold_reset;
    zero_low;
    for (int i = 0; i < 6; i++) load(10 + i, p[i]);
    start;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 14) begin
        n_cmp++;
        if (gpio_state !== 32'd0) begin
          n_fail++; $display("FAIL d9_before: got %h want %h", gpio_state, 32'd0);
        end
      end
      if (k == 15) begin
        n_cmp++;
        if (gpio_state !== 32'h0000_00D9) begin
          n_fail++; $display("FAIL d9_gpio: got %h want %h", gpio_state, 32'hD9);
        end
      end
      if (k == 15 || k == 20) begin
        n_cmp++;
        if (index !== 32'd15) begin
          n_fail++; $display("FAIL d9_index[%0d]: got %0d want %0d", k, index, 15);
        end
      end
    end
  endtask

  // Download mode: PC forced to 0, GPIO frozen.
  task automatic test_write_hold;
    write = 1'b1;
    write_instruction_index = 8'd200;
    write_instruction = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (index !== 32'd0) begin
        n_fail++; $display("FAIL hold_index[%0d]: got %0d want %0d", k, index, 0);
      end
      n_cmp++;
      if (gpio_state !== 32'h0000_00D9) begin
        n_fail++; $display("FAIL hold_gpio[%0d]: got %h want %h", k, gpio_state, 32'hD9);
      end
    end
  endtask

  task automatic test_countdown;
    logic [15:0] p [7];
    logic [31:0] seen [$];
    logic [31:0] last;
    p = '{16'h2021, 16'h0520, 16'h0860, 16'h0138, 16'h0028, 16'hFBD1, 16'hFEE7};
    hold_reset;
    zero_low;
    for (int i = 0; i < 7; i++) load(10 + i, p[i]);
    start;
    last = 32'd0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (gpio_state !== last) begin
        seen.push_back(gpio_state);
        last = gpio_state;
      end
    end
    n_cmp++;
    if (seen.size() != 5) begin
      n_fail++; $display("FAIL count_len: got %0d want %0d", seen.size(), 5);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) begin
        n_cmp++;
        if (seen[i] !== 32'(5 - i)) begin
          n_fail++; $display("FAIL count_val[%0d]: got %h want %h", i, seen[i], 32'(5 - i));
        end
      end
    end
    n_cmp++;
    if (index !== 32'd16) begin
      n_fail++; $display("FAIL count_park: got %0d want %0d", index, 16);
    end
  endtask

  task automatic test_chaser;
    logic [15:0] p [12];
    logic [31:0] seen [$];
    logic [31:0] last, want;
    logic        restart_seen;
    int          cyc;
    p = '{16'h2021, 16'h0022, 16'h0023, 16'h202B, 16'hFAD0, 16'h5200,
          16'h102B, 16'h00DA, 16'h0132, 16'h0133, 16'h0A60, 16'hF6E7};
    hold_reset;
    zero_low;
    for (int i = 0; i < 12; i++) load(10 + i, p[i]);
    start;
    last = 32'd0;
    restart_seen = 1'b0;
    cyc = 0;
    while (seen.size() < 33 && cyc < 800) begin
      @(negedge clk);
      cyc++;
      if (seen.size() == 32 && index == 32'd10) restart_seen = 1'b1;
      if (gpio_state !== last) begin
        seen.push_back(gpio_state);
        last = gpio_state;
      end
    end
    n_cmp++;
    if (seen.size() != 33) begin
      n_fail++; $display("FAIL chaser_len: got %0d want %0d", seen.size(), 33);
    end
    for (int j = 0; j < 33; j++) begin
      if (j < 16)      want = (32'h1 << (j + 1)) - 32'h1;
      else if (j < 32) want = 32'hFFFF << (j - 15);
      else             want = 32'h1;
      if (j < seen.size()) begin
        n_cmp++;
        if (seen[j] !== want) begin
          n_fail++; $display("FAIL chaser_val[%0d]: got %h want %h", j, seen[j], want);
        end
      end
    end
    n_cmp++;
    if (restart_seen !== 1'b1) begin
      n_fail++; $display("FAIL chaser_restart: got %0b want %0b", restart_seen, 1'b1);
    end
  endtask

  // Reset mid-run: immediate clear, program retained, chaser reruns.
  task automatic test_reset_midrun;
    logic [31:0] seen [$];
    logic [31:0] last;
    repeat (37) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (index !== 32'd0) begin
      n_fail++; $display("FAIL midrst_index: got %0d want %0d", index, 0);
    end
    n_cmp++;
    if (gpio_state !== 32'd0) begin
      n_fail++; $display("FAIL midrst_gpio: got %h want %h", gpio_state, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    last = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (gpio_state !== last) begin
        seen.push_back(gpio_state);
        last = gpio_state;
      end
    end
    n_cmp++;
    if (seen.size() < 2) begin
      n_fail++; $display("FAIL midrst_len: got %0d want %0d", seen.size(), 2);
    end else begin
      n_cmp++;
      if (seen[0] !== 32'h1) begin
        n_fail++; $display("FAIL midrst_first: got %h want %h", seen[0], 32'h1);
      end
      n_cmp++;
      if (seen[1] !== 32'h3) begin
        n_fail++; $display("FAIL midrst_second: got %h want %h", seen[1], 32'h3);
      end
    end
  endtask

  initial begin
    test_reset;
    test_sub_flags;
    test_alu;
    test_gpio_d9;
    test_write_hold;
    test_countdown;
    test_chaser;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
